// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state encoding and S-box geometry for the RC4 keystream generator
//
// Contents:
//   SBOX_SIZE    number of S-box entries (256)
//   SBOX_AW      S-box address / index width (8)
//   rc4_state_e  controller states
package rc4_pkg;

  localparam int SBOX_SIZE = 256;
  localparam int SBOX_AW   = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA_A,
    KSA_B,
    GEN_A,
    GEN_B,
    GEN_C,
    HOLD
  } rc4_state_e;

endpackage

// File: rtl/rc4_keystream_gen_if.sv
// rtl/rc4_keystream_gen_if.sv - key load / keystream handshake bundle
//
// Signals:
//   keyLoad   control -> gen  one-cycle pulse, capture key and restart
//   key       control -> gen  KEY_BYTES*8 key, key[7:0] is byte 0
//   keyLenM1  control -> gen  key length minus one
//   ksAbort   control -> gen  return generator to idle
//   ksReady   consumer -> gen consumer accepts ksData
//   ksValid   gen -> consumer ksData holds a keystream byte
//   ksData    gen -> consumer keystream byte
//   busy      gen -> control  key schedule in progress
// Modports: master (control/consumer side), slave (generator side).
interface rc4_keystream_gen_if #(
  parameter int KEY_BYTES = 16
);

  logic                   keyLoad;
  logic [KEY_BYTES*8-1:0] key;
  logic [3:0]             keyLenM1;
  logic                   ksAbort;
  logic                   ksReady;
  logic                   ksValid;
  logic [7:0]             ksData;
  logic                   busy;

  modport master (
    output keyLoad, key, keyLenM1, ksAbort, ksReady,
    input  ksValid, ksData, busy
  );

  modport slave (
    input  keyLoad, key, keyLenM1, ksAbort, ksReady,
    output ksValid, ksData, busy
  );

endinterface

// File: rtl/rc4_sbox.sv
// rtl/rc4_sbox.sv - 256x8 RC4 state array with two read ports, a swap port and an init port
//
// Ports:
//   clk          clock, writes on rising edge
//   rd_addr_a/b  combinational read addresses
//   rd_data_a/b  combinational read data
//   swap_en      write swap_data_a to swap_addr_a and swap_data_b to swap_addr_b
//   swap_addr_*  swap addresses; equal addresses give a single write of swap_data_a
//   swap_data_*  swap write data
//   init_en      write init_data to init_addr (takes precedence over swap)
//   init_addr    init write address
//   init_data    init write data
// The array has no reset: its contents are only meaningful after an init pass.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic               clk,
  input  logic [SBOX_AW-1:0] rd_addr_a,
  output logic [7:0]         rd_data_a,
  input  logic [SBOX_AW-1:0] rd_addr_b,
  output logic [7:0]         rd_data_b,
  input  logic               swap_en,
  input  logic [SBOX_AW-1:0] swap_addr_a,
  input  logic [SBOX_AW-1:0] swap_addr_b,
  input  logic [7:0]         swap_data_a,
  input  logic [7:0]         swap_data_b,
  input  logic               init_en,
  input  logic [SBOX_AW-1:0] init_addr,
  input  logic [7:0]         init_data
);

  logic [7:0] mem [SBOX_SIZE];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_addr] <= init_data;
    end else if (swap_en) begin
      mem[swap_addr_a] <= swap_data_a;
      // With equal addresses both data words are the same entry, so one write
      // keeps the entry unchanged.
      if (swap_addr_b != swap_addr_a) begin
        mem[swap_addr_b] <= swap_data_b;
      end
    end
  end

endmodule

// File: rtl/rc4_keystream_gen.sv
// rtl/rc4_keystream_gen.sv - RC4 key schedule and keystream byte generator with valid/ready output
//
// Ports:
//   macCoreClk         core clock, rising edge
//   macCoreClkSoftRst  synchronous active-high reset
//   ks                 rc4_keystream_gen_if.slave: keyLoad/key/keyLenM1/ksAbort/ksReady in,
//                      ksValid/ksData/busy out
// Parameters:
//   KEY_BYTES  maximum key length in bytes
//   DROP_N     keystream bytes discarded after the key schedule when RC4_DROP_EN is defined
// Build option: define RC4_DROP_EN to discard the first DROP_N keystream bytes internally.
module rc4_keystream_gen
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 16,
  parameter int DROP_N    = 256
) (
  input  logic             macCoreClk,
  input  logic             macCoreClkSoftRst,
  rc4_keystream_gen_if.slave ks
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  rc4_state_e state, state_next;

  logic [SBOX_AW-1:0]     i, i_next;
  logic [SBOX_AW-1:0]     j, j_next;
  logic [SBOX_AW-1:0]     t, t_next;
  logic [KW-1:0]          kidx, kidx_next;
  logic [KW-1:0]          len_m1, len_m1_next;
  logic [KEY_BYTES*8-1:0] key_reg, key_next;
  logic                   ks_valid, ks_valid_next;
  logic [7:0]             ks_data, ks_data_next;
  logic                   busy_r, busy_next;

  logic [SBOX_AW-1:0]     rd_addr_a;
  logic [7:0]             rd_data_a, rd_data_b;
  logic                   swap_en, init_en;
  logic [7:0]             key_byte;
  logic                   drop_phase;

`ifdef RC4_DROP_EN
  localparam int DW = $clog2(DROP_N + 1);
  logic [DW-1:0] drop_cnt, drop_cnt_next;
`else
  wire unused_drop_n = (DROP_N != 0);
`endif

  rc4_sbox u_sbox (
    .clk         (macCoreClk),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (j),
    .rd_data_b   (rd_data_b),
    .swap_en     (swap_en),
    .swap_addr_a (i),
    .swap_addr_b (j),
    .swap_data_a (rd_data_b),
    .swap_data_b (rd_data_a),
    .init_en     (init_en),
    .init_addr   (i),
    .init_data   (i)
  );

  // kidx tracks i mod key length incrementally, which avoids a divider.
  assign key_byte = key_reg[{kidx, 3'b000} +: 8];

  always_comb begin
`ifdef RC4_DROP_EN
    drop_phase = (drop_cnt != DW'(DROP_N));
`else
    drop_phase = 1'b0;
`endif
  end

  always_comb begin
    state_next    = state;
    i_next        = i;
    j_next        = j;
    t_next        = t;
    kidx_next     = kidx;
    len_m1_next   = len_m1;
    key_next      = key_reg;
    ks_valid_next = ks_valid;
    ks_data_next  = ks_data;
    busy_next     = busy_r;
    rd_addr_a     = i;
    swap_en       = 1'b0;
    init_en       = 1'b0;
`ifdef RC4_DROP_EN
    drop_cnt_next = drop_cnt;
`endif

    if (macCoreClkSoftRst) begin
      // register reset handled in the state register; no S-box writes
    end else if (ks.ksAbort) begin
      state_next    = IDLE;
      ks_valid_next = 1'b0;
      busy_next     = 1'b0;
    end else if (ks.keyLoad) begin
      state_next    = INIT;
      i_next        = '0;
      j_next        = '0;
      kidx_next     = '0;
      key_next      = ks.key;
      if (int'(ks.keyLenM1) >= KEY_BYTES) begin
        len_m1_next = KW'(KEY_BYTES - 1);
      end else begin
        len_m1_next = KW'(ks.keyLenM1);
      end
      ks_valid_next = 1'b0;
      busy_next     = 1'b1;
`ifdef RC4_DROP_EN
      drop_cnt_next = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
        end
        INIT: begin
          // i doubles as the fill counter: S[i] = i
          init_en = 1'b1;
          if (i == 8'hFF) begin
            i_next     = '0;
            j_next     = '0;
            kidx_next  = '0;
            state_next = KSA_A;
          end else begin
            i_next = i + 8'd1;
          end
        end
        KSA_A: begin
          j_next     = j + rd_data_a + key_byte;
          state_next = KSA_B;
        end
        KSA_B: begin
          swap_en = 1'b1;
          if (i == 8'hFF) begin
            i_next     = '0;
            j_next     = '0;
            state_next = GEN_A;
          end else begin
            i_next     = i + 8'd1;
            kidx_next  = (kidx == len_m1) ? '0 : kidx + 1'b1;
            state_next = KSA_A;
          end
        end
        GEN_A: begin
          // look ahead at S[i+1] so i and j advance in one cycle
          rd_addr_a  = i + 8'd1;
          i_next     = i + 8'd1;
          j_next     = j + rd_data_a;
          state_next = GEN_B;
        end
        GEN_B: begin
          swap_en    = 1'b1;
          t_next     = rd_data_a + rd_data_b;
          state_next = GEN_C;
        end
        GEN_C: begin
          rd_addr_a = t;
          if (drop_phase) begin
`ifdef RC4_DROP_EN
            drop_cnt_next = drop_cnt + 1'b1;
`endif
            state_next = GEN_A;
          end else begin
            ks_data_next  = rd_data_a;
            ks_valid_next = 1'b1;
            busy_next     = 1'b0;
            state_next    = HOLD;
          end
        end
        HOLD: begin
          if (ks_valid && ks.ksReady) begin
            ks_valid_next = 1'b0;
            state_next    = GEN_A;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge macCoreClk) begin
    if (macCoreClkSoftRst) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      t        <= '0;
      kidx     <= '0;
      len_m1   <= '0;
      key_reg  <= '0;
      ks_valid <= 1'b0;
      ks_data  <= '0;
      busy_r   <= 1'b0;
`ifdef RC4_DROP_EN
      drop_cnt <= '0;
`endif
    end else begin
      state    <= state_next;
      i        <= i_next;
      j        <= j_next;
      t        <= t_next;
      kidx     <= kidx_next;
      len_m1   <= len_m1_next;
      key_reg  <= key_next;
      ks_valid <= ks_valid_next;
      ks_data  <= ks_data_next;
      busy_r   <= busy_next;
`ifdef RC4_DROP_EN
      drop_cnt <= drop_cnt_next;
`endif
    end
  end

  assign ks.ksValid = ks_valid;
  assign ks.ksData  = ks_data;
  assign ks.busy    = busy_r;

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// tb/tb_rc4_keystream_gen.sv - scoreboard bench for rc4_keystream_gen against an array-based RC4 model
module tb_rc4_keystream_gen;

  localparam int KB = 16;
`ifdef RC4_DROP_EN
  localparam int DROP = 256;
`else
  localparam int DROP = 0;
`endif
  localparam int FIRST_LAT = 771 + 3 * DROP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc4_keystream_gen_if #(.KEY_BYTES(KB)) ks_if ();

  rc4_keystream_gen #(.KEY_BYTES(KB), .DROP_N(256)) dut (
    .macCoreClk        (clk),
    .macCoreClkSoftRst (rst),
    .ks                (ks_if)
  );

  int errors  = 0;
  int checks  = 0;
  int got_cnt = 0;
  int exp_q[$];
  int ref_ks[$];
  int kat_q[$];
  bit hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  int kat_key[10] = '{'hEB, 'h9F, 'h77, 'h81, 'hB7, 'h34, 'hCA, 'h72, 'hA7, 'h19};
  int kat_wiki[6] = '{'h60, 'h44, 'hDB, 'h6D, 'h41, 'hB7};
  int kat_sec[8]  = '{'h04, 'hD4, 'h6B, 'h05, 'h3C, 'hA8, 'h7B, 'h59};

  localparam logic [127:0] KEY_KEY  = 128'h79654B;
  localparam logic [127:0] KEY_WIKI = 128'h696B6957;
  localparam logic [127:0] KEY_SEC  = 128'h746572636553;

  // Scoreboard monitor: pops one expected byte per accepted handshake.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!(ks_if.ksValid && ks_if.ksData == hold_data)) begin
          errors++;
          $display("FAIL hold_stable actual valid=%0b data=%02h required valid=1 data=%02h",
                   ks_if.ksValid, ks_if.ksData, hold_data);
        end
      end
      if (ks_if.ksValid && ks_if.ksReady && !ks_if.keyLoad && !ks_if.ksAbort) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=%02h required=none", ks_if.ksData);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(ks_if.ksData) != e) begin
            errors++;
            $display("FAIL ks_byte actual=%02h required=%02h", ks_if.ksData, e);
          end
        end
        got_cnt++;
      end
      hold_prev = ks_if.ksValid && !ks_if.ksReady && !ks_if.keyLoad && !ks_if.ksAbort;
      hold_data = ks_if.ksData;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Textbook RC4: KSA over the key, then PRGA; the first DROP bytes are skipped.
  task automatic ref_gen(input logic [127:0] k, input int len, input int n);
    int s[256];
    int a, b, tmp;
    ref_ks.delete();
    for (int x = 0; x < 256; x++) s[x] = x;
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = (b + s[x] + int'(k[8*(x % len) +: 8])) % 256;
      tmp = s[x]; s[x] = s[b]; s[b] = tmp;
    end
    a = 0;
    b = 0;
    for (int c = 0; c < DROP + n; c++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      tmp = s[a]; s[a] = s[b]; s[b] = tmp;
      if (c >= DROP) ref_ks.push_back(s[(s[a] + s[b]) % 256]);
    end
  endtask

  task automatic kat_set(input int which);
    kat_q.delete();
    case (which)
      1: for (int x = 0; x < 10; x++) kat_q.push_back(kat_key[x]);
      2: for (int x = 0; x < 6; x++)  kat_q.push_back(kat_wiki[x]);
      3: for (int x = 0; x < 8; x++)  kat_q.push_back(kat_sec[x]);
      default: ;
    endcase
  endtask

  task automatic start_load(input logic [127:0] k, input logic [3:0] lm1);
    @(posedge clk); #1;
    exp_q.delete();
    ks_if.key      = k;
    ks_if.keyLenM1 = lm1;
    ks_if.keyLoad  = 1'b1;
    ks_if.ksReady  = 1'b1;
    @(posedge clk); #1;
    ks_if.keyLoad  = 1'b0;
  endtask

  task automatic wait_first();
    int cnt;
    bit busy_ok;
    cnt = 0;
    busy_ok = 1'b1;
    check("valid_after_load", int'(ks_if.ksValid), 0);
    check("busy_after_load", int'(ks_if.busy), 1);
    while (!ks_if.ksValid && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
      if (!ks_if.ksValid && !ks_if.busy) busy_ok = 1'b0;
    end
    check("first_latency", cnt, FIRST_LAT);
    check("busy_held", int'(busy_ok), 1);
    check("busy_fall", int'(ks_if.busy), 0);
  endtask

  task automatic wait_bytes(input int n, input bit rand_ready);
    int target, cyc;
    target = got_cnt + n;
    cyc = 0;
    while (got_cnt < target && cyc < n * 40 + 200) begin
      @(posedge clk); #1;
      cyc++;
      if (rand_ready) ks_if.ksReady = 1'($urandom_range(0, 1));
    end
    ks_if.ksReady = 1'b1;
    check("bytes_delivered", int'(got_cnt >= target), 1);
  endtask

  task automatic run_load(input logic [127:0] k, input logic [3:0] lm1, input int n,
                          input int kat, input bit rand_ready);
    start_load(k, lm1);
    ref_gen(k, int'(lm1) + 1, n + 16);
    kat_set(kat);
    for (int c = 0; c < n + 16; c++) begin
      if (DROP == 0 && c < kat_q.size()) exp_q.push_back(kat_q[c]);
      else                               exp_q.push_back(ref_ks[c]);
    end
    wait_first();
    wait_bytes(n, rand_ready);
  endtask

  task automatic wait_valid();
    int cyc;
    cyc = 0;
    while (!ks_if.ksValid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("valid_seen", int'(ks_if.ksValid), 1);
  endtask

  task automatic quiet(input string name, input int n);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      if (ks_if.ksValid || ks_if.busy) ok = 1'b0;
    end
    check(name, int'(ok), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rk;
    logic [3:0]   rl;

    rst = 1'b1;
    ks_if.keyLoad  = 1'b0;
    ks_if.key      = '0;
    ks_if.keyLenM1 = '0;
    ks_if.ksAbort  = 1'b0;
    ks_if.ksReady  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(ks_if.ksValid), 0);
    check("reset_data", int'(ks_if.ksData), 0);
    check("reset_busy", int'(ks_if.busy), 0);
    rst = 1'b0;

    // Known-answer keys; upper key bytes beyond the length carry junk.
    run_load(KEY_KEY | (128'hA5 << 96), 4'd2, 10, 1, 1'b0);
    run_load(KEY_WIKI | (128'h5A << 64), 4'd3, 6, 2, 1'b0);
    run_load(KEY_SEC, 4'd5, 8, 3, 1'b0);

    // Random keys including the shortest and longest lengths.
    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rl = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      run_load(rk, rl, 20, 0, 1'b0);
    end

    // Backpressure over 1000 bytes, then the same key with ready held high.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rl = 4'($urandom_range(0, 15));
    run_load(rk, rl, 1000, 0, 1'b1);
    run_load(rk, rl, 1000, 0, 1'b0);

    // Restart mid-KSA, then again while a byte is held.
    start_load({$urandom, $urandom, $urandom, $urandom}, 4'd7);
    repeat (400) @(posedge clk);
    run_load(KEY_WIKI, 4'd3, 2, 2, 1'b0);
    @(posedge clk); #1;
    ks_if.ksReady = 1'b0;
    wait_valid();
    repeat (5) @(posedge clk);
    run_load(KEY_WIKI, 4'd3, 6, 2, 1'b0);

    // Reset while the datapath sits in GEN_B.
    run_load(KEY_KEY, 4'd2, 3, 1, 1'b0);
    wait_valid();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_gen_valid", int'(ks_if.ksValid), 0);
    check("rst_gen_data", int'(ks_if.ksData), 0);
    check("rst_gen_busy", int'(ks_if.busy), 0);
    rst = 1'b0;
    quiet("idle_after_reset", 100);

    // Abort while holding a byte.
    run_load(KEY_KEY, 4'd2, 3, 1, 1'b0);
    @(posedge clk); #1;
    ks_if.ksReady = 1'b0;
    wait_valid();
    @(posedge clk); #1;
    ks_if.ksAbort = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    ks_if.ksAbort = 1'b0;
    check("abort_valid", int'(ks_if.ksValid), 0);
    check("abort_busy", int'(ks_if.busy), 0);
    ks_if.ksReady = 1'b1;
    quiet("idle_after_abort", 100);
    run_load(KEY_KEY, 4'd2, 10, 1, 1'b0);

    @(posedge clk); #1;
    ks_if.ksAbort = 1'b1;
    @(posedge clk); #1;
    ks_if.ksAbort = 1'b0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
